nes_cart_mem_arb: RTL
=====================

# nes_cart_mem_arb

Bus initiator on the memory side of the cartridge mappers. It takes the translated PRG (CPU) and CHR (PPU) accesses produced by the active mapper, including the allow and VRAM-routing outputs, and serializes them onto the single external memory port with a req/ack handshake. Read data is returned to each channel with a valid pulse. It sits between the mapper bus (`prg_aout_b`/`chr_aout_b` resolved nets) and the SDRAM controller.

## Interface
- `VRAM_BASE`, 22'h38_0000: base address of the internal 2 kB VRAM window.
- `PRG_MAX_WAIT`, 6: cycles a pending PRG request may lose arbitration before it is forced to win.
- `clk`  in  1  system clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `prg_read`, `prg_write`  in  1  one-cycle CPU access strobes.
- `prg_aout`  in  22  mapper-translated PRG address.
- `prg_allow`  in  1  mapper permits the access.
- `prg_din`  in  8  CPU write data.
- `prg_rdata`  out  8  PRG read data.
- `prg_rvalid`  out  1  one-cycle pulse when `prg_rdata` is valid.
- `chr_read`, `chr_write`  in  1  one-cycle PPU access strobes.
- `chr_aout`  in  22  mapper-translated CHR address.
- `chr_allow`  in  1  CHR write permitted (CHR RAM).
- `vram_ce`, `vram_a10`  in  1  route to internal VRAM, and VRAM A10.
- `chr_ain`  in  14  raw PPU address (bits 9:0 used for VRAM).
- `chr_din`  in  8  PPU write data.
- `chr_rdata`  out  8  CHR read data.
- `chr_rvalid`  out  1  one-cycle read-valid pulse.
- `mem_addr`  out  22  external address.
- `mem_wdata`  out  8  external write data.
- `mem_rd`, `mem_wr`  out  1  command qualifiers, valid while `mem_req`.
- `mem_req`  out  1  request, held until ack.
- `mem_ack`  in  1  one-cycle completion pulse; read data valid with it.
- `mem_rdata`  in  8  external read data.
- `ovf`  out  1  sticky: a strobe arrived on a channel already pending.

## Operation
- **Capture.** A strobe is registered into that channel's pending slot, which holds the address, data, direction and the `allow` decision.
- **CHR address.** When `vram_ce` is set, the captured CHR address is `VRAM_BASE | {vram_a10, chr_ain[9:0]}`; otherwise it is `chr_aout`.
- **Disallowed reads.** Reads with allow=0 are never issued. They complete with rdata=8'hFF, and the valid pulse fires 1 cycle after the strobe.
- **Disallowed writes.** Writes with allow=0 are dropped silently. VRAM writes are always allowed.
- **Overflow.** A strobe on a channel whose slot is still pending is dropped and sets `ovf`. Only reset clears `ovf`.
- **Arbitration.** Evaluated in IDLE. CHR has fixed priority over PRG. Exception: when PRG's wait counter equals `PRG_MAX_WAIT`, PRG wins.
  - The wait counter increments each IDLE cycle that PRG is pending but not granted. It saturates at the limit and clears on grant.
- **FSM.**
  - IDLE: if any issuable slot exists, grant it, drive `mem_*` and go to BUSY.
  - BUSY: hold `mem_req`, `mem_addr`, `mem_wdata`, `mem_rd` and `mem_wr` stable. On `mem_ack`, free the slot and go to DONE.
  - DONE: pulse the owner's `rvalid` (reads only) with the data latched at ack, then go to IDLE.
- **Same-channel back-to-back.** A strobe arriving on the same cycle the slot frees (the ack cycle) is accepted, not counted as overflow.
- **Reset.** Clears every slot, counter, `ovf` and output; the FSM returns to IDLE. An ack arriving after reset with no outstanding request is ignored.

## Timing
- **Reset values.** All outputs are 0. rdata is 8'h00.
- **Allowed read latency.** Strobe at cycle 0, slot valid at cycle 1, `mem_req` rises at cycle 1 if granted. With ack at cycle k, `rvalid` fires at cycle k+1.
  - Minimum strobe-to-rvalid: 3 cycles, when ack arrives on the cycle after `mem_req` rises.
- **Write.** Same issue timing; no completion pulse.
- **Handshake.** `mem_req` falls the cycle after ack. Minimum one IDLE cycle between requests.
- **Simultaneous strobes.** PRG and CHR strobes in the same cycle are both captured. CHR issues first unless the PRG limit is reached.

## Structure
- Shared package `nes_mem_pkg`:
  - the state enum (IDLE, BUSY, DONE);
  - a channel-slot struct {valid, wr, addr[21:0], data[7:0], allow};
  - `VRAM_BASE`.
- Sub-module `nes_mem_slot`: instantiated twice, one per channel. It owns capture, overflow detection and the disallowed-read bypass.
- The arbiter and FSM live in the top block.

## Test plan
- **PRG read.** Stimulus: PRG read, allow=1, addr 22'h01_2345; ack 2 cycles after req with mem_rdata=8'hA5. Required: `mem_addr`=22'h01_2345 with `mem_rd`=1, then `prg_rvalid` with 8'hA5 on the cycle after ack.
- **VRAM routing.** Stimulus: CHR read with vram_ce=1, vram_a10=1, chr_ain=14'h2155. Required: `mem_addr`=22'h38_0555.
- **Priority and starvation guard.**
  - Simultaneous PRG and CHR reads: CHR is issued first, PRG second.
  - With CHR re-strobed continuously, PRG is granted after at most 6 lost arbitrations.
- **Disallowed access.**
  - PRG read with allow=0: no `mem_req`; `prg_rvalid` fires 1 cycle later with 8'hFF.
  - CHR write with chr_allow=0: no `mem_req`.
- **Overflow.** A second PRG strobe while the first is pending sets `ovf`=1 and produces only one `mem_req`.
- **Reset mid-operation.** `reset_n`=0 while in BUSY: `mem_req` is 0 the next cycle, and a late ack produces no `rvalid`.

Source files
------------

// File: rtl/nes_mem_pkg.sv
// nes_mem_pkg: shared types and constants for the cartridge memory arbiter.
package nes_mem_pkg;
  localparam logic [21:0] VRAM_BASE = 22'h38_0000;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  data;
    logic        allow;
  } slot_t;
endpackage

// File: rtl/nes_mem_slot.sv
// nes_mem_slot: one channel's pending slot with capture, overflow and disallowed-read bypass.
module nes_mem_slot
  import nes_mem_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_read,
  input  logic        i_write,
  input  logic [21:0] i_addr,
  input  logic [7:0]  i_data,
  input  logic        i_allow,
  input  logic        i_free,
  output slot_t       o_pend,
  output logic        o_byp_valid,
  output logic        o_ovf
);
  slot_t r_slot;
  logic  r_byp;
  logic  r_ovf;
  slot_t w_new;
  logic  w_stb;
  logic  w_busy;
  logic  w_take;
  assign w_stb  = i_read | i_write;
  assign w_busy = r_slot.valid & ~i_free;
  assign w_take = w_stb & ~w_busy;
  assign w_new  = '{valid: w_take & i_allow, wr: i_write, addr: i_addr, data: i_data, allow: i_allow};
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_slot <= '0;
      r_byp  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_take) r_slot <= w_new;
      else if (i_free) r_slot.valid <= 1'b0;
      r_byp <= w_take & ~i_write & ~i_allow;
      r_ovf <= r_ovf | (w_stb & w_busy);
    end
  end
  // An idle slot exposes the incoming strobe so arbitration can grant it on the capture edge.
  assign o_pend      = r_slot.valid ? r_slot : w_new;
  assign o_byp_valid = r_byp;
  assign o_ovf       = r_ovf;
endmodule

// File: rtl/nes_cart_mem_arb.sv
// nes_cart_mem_arb: serializes mapper PRG/CHR accesses onto one req/ack memory port.
module nes_cart_mem_arb
  import nes_mem_pkg::*;
#(
  parameter int PRG_MAX_WAIT = 6
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_prg_read,
  input  logic        i_prg_write,
  input  logic [21:0] i_prg_aout,
  input  logic        i_prg_allow,
  input  logic [7:0]  i_prg_din,
  output logic [7:0]  o_prg_rdata,
  output logic        o_prg_rvalid,
  input  logic        i_chr_read,
  input  logic        i_chr_write,
  input  logic [21:0] i_chr_aout,
  input  logic        i_chr_allow,
  input  logic        i_vram_ce,
  input  logic        i_vram_a10,
  input  logic [13:0] i_chr_ain,
  input  logic [7:0]  i_chr_din,
  output logic [7:0]  o_chr_rdata,
  output logic        o_chr_rvalid,
  output logic [21:0] o_mem_addr,
  output logic [7:0]  o_mem_wdata,
  output logic        o_mem_rd,
  output logic        o_mem_wr,
  output logic        o_mem_req,
  input  logic        i_mem_ack,
  input  logic [7:0]  i_mem_rdata,
  output logic        o_ovf
);
  localparam int WW = $clog2(PRG_MAX_WAIT + 1);
  state_t      r_state;
  state_t      w_next;
  logic        r_own_chr;
  logic [7:0]  r_rdata;
  logic [WW-1:0] r_wait;
  logic        r_req;
  logic        r_rd;
  logic        r_wr;
  logic [21:0] r_addr;
  logic [7:0]  r_wdata;
  slot_t       w_prg;
  slot_t       w_chr;
  slot_t       w_sel;
  logic        w_prg_byp;
  logic        w_chr_byp;
  logic        w_prg_ovf;
  logic        w_chr_ovf;
  logic [21:0] w_chr_addr;
  logic        w_chr_allow;
  logic        w_prg_win;
  logic        w_grant;
  logic        w_ack;
  logic        w_done_prg;
  logic        w_done_chr;
  logic        w_unused;
  assign w_chr_addr  = i_vram_ce ? (VRAM_BASE | {11'd0, i_vram_a10, i_chr_ain[9:0]}) : i_chr_aout;
  // CHR reads (ROM or RAM) and all VRAM traffic are always allowed; only CHR writes need permission.
  assign w_chr_allow = i_vram_ce | i_chr_allow | (i_chr_read & ~i_chr_write);
  nes_mem_slot u_prg (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_read(i_prg_read), .i_write(i_prg_write),
    .i_addr(i_prg_aout), .i_data(i_prg_din), .i_allow(i_prg_allow),
    .i_free(w_ack & ~r_own_chr), .o_pend(w_prg), .o_byp_valid(w_prg_byp), .o_ovf(w_prg_ovf)
  );
  nes_mem_slot u_chr (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_read(i_chr_read), .i_write(i_chr_write),
    .i_addr(w_chr_addr), .i_data(i_chr_din), .i_allow(w_chr_allow),
    .i_free(w_ack & r_own_chr), .o_pend(w_chr), .o_byp_valid(w_chr_byp), .o_ovf(w_chr_ovf)
  );
  assign w_prg_win = w_prg.valid & (~w_chr.valid | r_wait == WW'(PRG_MAX_WAIT));
  assign w_grant   = (r_state == S_IDLE) & (w_prg.valid | w_chr.valid);
  assign w_ack     = (r_state == S_BUSY) & i_mem_ack;
  assign w_sel     = w_prg_win ? w_prg : w_chr;
  always_comb begin
    w_next     = r_state;
    w_next     = (r_state == S_IDLE) ? (w_grant ? S_BUSY : S_IDLE) :
                 (r_state == S_BUSY) ? (i_mem_ack ? S_DONE : S_BUSY) : S_IDLE;
    w_done_prg = (r_state == S_DONE) & ~r_own_chr & r_rd;
    w_done_chr = (r_state == S_DONE) & r_own_chr & r_rd;
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= S_IDLE;
      r_own_chr <= 1'b0;
      r_rdata   <= 8'h00;
      r_wait    <= '0;
      r_req     <= 1'b0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= 8'h00;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_req     <= 1'b1;
        r_rd      <= ~w_sel.wr;
        r_wr      <= w_sel.wr;
        r_addr    <= w_sel.addr;
        r_wdata   <= w_sel.data;
        r_own_chr <= ~w_prg_win;
      end else if (w_ack) begin
        r_req   <= 1'b0;
        r_rdata <= i_mem_rdata;
      end
      if (w_grant & w_prg_win) r_wait <= '0;
      else if (w_grant & w_prg.valid & r_wait != WW'(PRG_MAX_WAIT)) r_wait <= r_wait + 1'b1;
    end
  end
  assign o_mem_req    = r_req;
  assign o_mem_rd     = r_rd;
  assign o_mem_wr     = r_wr;
  assign o_mem_addr   = r_addr;
  assign o_mem_wdata  = r_wdata;
  assign o_prg_rvalid = w_done_prg | w_prg_byp;
  assign o_chr_rvalid = w_done_chr | w_chr_byp;
  assign o_prg_rdata  = w_done_prg ? r_rdata : w_prg_byp ? 8'hFF : 8'h00;
  assign o_chr_rdata  = w_done_chr ? r_rdata : w_chr_byp ? 8'hFF : 8'h00;
  assign o_ovf        = w_prg_ovf | w_chr_ovf;
  assign w_unused     = ^{i_chr_ain[13:10], w_prg.allow, w_chr.allow, w_sel.valid, w_sel.allow};
endmodule
